// File: rtl/aes_pkg.sv
// Shared AES definitions: word/block types, round-count and round-constant
// defaults, GF(2^8) doubling and the forward S-box used by SubWord/SubBytes.
package aes_pkg;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_block_t;

  localparam int         AES_NR    = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  localparam logic [7:0] AES_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: independent S-box lookup on each of the four bytes of a word.
module aes_sub_word
  import aes_pkg::*;
(
  input  aes_word_t word,
  output aes_word_t sub
);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      assign sub[8*gi +: 8] = AES_SBOX[word[8*gi +: 8]];
    end
  endgenerate

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per round_key_en pulse,
// with the final round key retained for the decryption path.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int         NR        = AES_NR,
  parameter logic [7:0] RCON_INIT = aes_pkg::RCON_INIT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] cipher_key,
  input  logic         key_load,
  input  logic         round_key_en,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         key_busy,
  output logic [127:0] last_key,
  output logic         last_key_valid
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_EXPAND = 1'b1;
  localparam logic [3:0] LAST_IDX  = 4'(NR);

  logic [0:0] state_reg, state_next;
  aes_block_t round_key_reg, round_key_next;
  logic [7:0] rcon_reg, rcon_next;
  logic [3:0] round_idx_reg, round_idx_next;
  aes_block_t last_key_reg, last_key_next;
  logic       last_key_valid_reg, last_key_valid_next;

  // A single expansion datapath serves both the load and the advance:
  // on load it starts from the cipher key with the first round constant.
  aes_block_t src_key;
  logic [7:0] src_rcon;
  aes_word_t  rot_out;
  aes_word_t  sub_out;
  aes_word_t  t_word;
  aes_word_t  w0, w1, w2, w3;
  aes_block_t expanded;

  assign src_key  = key_load ? cipher_key : round_key_reg;
  assign src_rcon = key_load ? RCON_INIT : rcon_reg;
  assign rot_out  = rot_word(src_key[31:0]);

  aes_sub_word u_sub_word (
    .word (rot_out),
    .sub  (sub_out)
  );

  always_comb begin
    t_word   = sub_out ^ {src_rcon, 24'h0};
    w0       = src_key[127:96] ^ t_word;
    w1       = src_key[95:64]  ^ w0;
    w2       = src_key[63:32]  ^ w1;
    w3       = src_key[31:0]   ^ w2;
    expanded = {w0, w1, w2, w3};
  end

  always_comb begin
    state_next          = state_reg;
    round_key_next      = round_key_reg;
    rcon_next           = rcon_reg;
    round_idx_next      = round_idx_reg;
    last_key_next       = last_key_reg;
    last_key_valid_next = last_key_valid_reg;

    if (key_load) begin
      state_next          = ST_EXPAND;
      round_key_next      = expanded;
      rcon_next           = xtime(RCON_INIT);
      round_idx_next      = 4'd1;
      last_key_valid_next = 1'b0;
    end else begin
      case (state_reg)
        ST_EXPAND: begin
          if (round_key_en) begin
            if (round_idx_reg < LAST_IDX) begin
              round_key_next = expanded;
              rcon_next      = xtime(rcon_reg);
              round_idx_next = round_idx_reg + 4'd1;
            end else begin
              // Final key has been consumed: keep it on round_key and archive it.
              state_next          = ST_IDLE;
              last_key_next       = round_key_reg;
              last_key_valid_next = 1'b1;
              round_idx_next      = 4'd0;
              rcon_next           = RCON_INIT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= ST_IDLE;
      round_key_reg      <= '0;
      rcon_reg           <= RCON_INIT;
      round_idx_reg      <= 4'd0;
      last_key_reg       <= '0;
      last_key_valid_reg <= 1'b0;
    end else begin
      state_reg          <= state_next;
      round_key_reg      <= round_key_next;
      rcon_reg           <= rcon_next;
      round_idx_reg      <= round_idx_next;
      last_key_reg       <= last_key_next;
      last_key_valid_reg <= last_key_valid_next;
    end
  end

  assign round_key      = round_key_reg;
  assign round_idx      = round_idx_reg;
  assign key_busy       = (state_reg == ST_EXPAND);
  assign last_key       = last_key_reg;
  assign last_key_valid = last_key_valid_reg;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: a word-level key-schedule model
// (S-box derived from GF(2^8) inversion) feeds a cycle-tagged scoreboard.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] cipher_key = '0;
  logic         key_load = 1'b0;
  logic         round_key_en = 1'b0;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_busy;
  logic [127:0] last_key;
  logic         last_key_valid;

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk            (clk),
    .reset          (reset),
    .cipher_key     (cipher_key),
    .key_load       (key_load),
    .round_key_en   (round_key_en),
    .round_key      (round_key),
    .round_idx      (round_idx),
    .key_busy       (key_busy),
    .last_key       (last_key),
    .last_key_valid (last_key_valid)
  );

  typedef struct {
    int           cyc;
    logic [127:0] rk;
    logic [3:0]   idx;
    logic         busy;
    logic [127:0] lk;
    logic         lkv;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [7:0]   sbox_m [256];
  logic [127:0] m_ks [0:10];
  logic [127:0] m_rk = '0;
  logic [127:0] m_last = '0;
  int           m_idx = 0;
  bit           m_busy = 0;
  bit           m_lkv = 0;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv = 8'h01;
      logic [7:0] b;
      for (int e = 0; e < 254; e++) inv = gf_mul(inv, 8'(v));
      if (v == 0) inv = 8'h00;
      b = inv;
      sbox_m[v] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                  ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      logic [31:0] t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) m_ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Drive one cycle of stimulus and queue what the outputs must be after it.
  task automatic tick(input logic r, input logic l, input logic e, input logic [127:0] k);
    exp_t x;
    @(negedge clk);
    reset = r; key_load = l; round_key_en = e; cipher_key = k;
    if (r) begin
      m_rk = '0; m_idx = 0; m_busy = 0; m_last = '0; m_lkv = 0;
    end else if (l) begin
      expand(k);
      m_rk = m_ks[1]; m_idx = 1; m_busy = 1; m_lkv = 0;
    end else if (e && m_busy) begin
      if (m_idx < 10) begin
        m_idx++;
        m_rk = m_ks[m_idx];
      end else begin
        m_last = m_rk; m_lkv = 1; m_busy = 0; m_idx = 0;
      end
    end
    x.cyc = cyc + 1; x.rk = m_rk; x.idx = 4'(m_idx); x.busy = m_busy;
    x.lk = m_last; x.lkv = m_lkv;
    sb_q.push_back(x);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: compare DUT outputs against the scoreboard entry for this cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      exp_t x;
      x = sb_q.pop_front();
      n_tests++;
      if (round_key !== x.rk || round_idx !== x.idx || key_busy !== x.busy ||
          last_key !== x.lk || last_key_valid !== x.lkv) begin
        n_fail++;
        $display("[TB] FAIL cycle %0d: got rk=%h idx=%0d busy=%0b lk=%h lkv=%0b, expected rk=%h idx=%0d busy=%0b lk=%h lkv=%0b",
                 cyc, round_key, round_idx, key_busy, last_key, last_key_valid,
                 x.rk, x.idx, x.busy, x.lk, x.lkv);
      end else begin
        $display("[TB] cycle %0d ok: idx=%0d busy=%0b lkv=%0b rk=%h", cyc, x.idx, x.busy, x.lkv, x.rk);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  initial begin
    logic [127:0] rkey;
    build_sbox();

    tick(1, 0, 0, '0);
    tick(1, 0, 0, '0);
    settle();
    chk("reset round_key", round_key, '0);
    chk("reset round_idx", 128'(round_idx), 128'd0);
    chk("reset key_busy", 128'(key_busy), 128'd0);
    chk("reset last_key", last_key, '0);
    chk("reset last_key_valid", 128'(last_key_valid), 128'd0);

    // FIPS-197 key with gaps between advance pulses
    tick(0, 1, 0, FIPS_KEY);
    settle();
    chk("fips rk1", round_key, FIPS_RK1);
    chk("fips rk1 idx", 128'(round_idx), 128'd1);
    for (int i = 0; i < 9; i++) begin
      tick(0, 0, 1, '0);
      if (i % 3 == 0) tick(0, 0, 0, '0);
    end
    settle();
    chk("fips rk10", round_key, FIPS_RK10);
    tick(0, 0, 1, '0);
    settle();
    chk("fips last_key", last_key, FIPS_RK10);
    chk("fips last_key_valid", 128'(last_key_valid), 128'd1);
    chk("fips busy done", 128'(key_busy), 128'd0);

    // Zero key
    tick(0, 1, 0, '0);
    settle();
    chk("zero rk1", round_key, ZERO_RK1);
    for (int i = 0; i < 9; i++) tick(0, 0, 1, '0);
    settle();
    chk("zero rk10", round_key, ZERO_RK10);
    tick(0, 0, 1, '0);

    // Restart at round 5 with a new key
    tick(0, 1, 0, {$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 4; i++) tick(0, 0, 1, '0);
    rkey = {$urandom, $urandom, $urandom, $urandom};
    tick(0, 1, 0, rkey);
    settle();
    chk("abort rk1", round_key, m_ks[1]);
    chk("abort idx", 128'(round_idx), 128'd1);
    chk("abort last_key kept", last_key, ZERO_RK10);
    chk("abort last_key_valid", 128'(last_key_valid), 128'd0);

    // Load and advance together mid-schedule
    tick(0, 0, 1, '0);
    tick(0, 0, 1, '0);
    rkey = {$urandom, $urandom, $urandom, $urandom};
    tick(0, 1, 1, rkey);
    settle();
    chk("load+en rk1", round_key, m_ks[1]);
    chk("load+en idx", 128'(round_idx), 128'd1);

    // Finish, then pulse while idle
    for (int i = 0; i < 10; i++) tick(0, 0, 1, '0);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, '0);
    settle();
    chk("idle round_key held", round_key, m_ks[10]);
    chk("idle last_key held", last_key, m_ks[10]);
    chk("idle idx", 128'(round_idx), 128'd0);

    // Reset at round 7, then reload
    tick(0, 1, 0, FIPS_KEY);
    for (int i = 0; i < 6; i++) tick(0, 0, 1, '0);
    tick(1, 0, 0, '0);
    settle();
    chk("midreset round_key", round_key, '0);
    chk("midreset last_key", last_key, '0);
    chk("midreset busy", 128'(key_busy), 128'd0);
    tick(0, 1, 0, FIPS_KEY);
    settle();
    chk("post-reset rk1", round_key, FIPS_RK1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic r, l, e;
      r = ($urandom_range(0, 63) == 0);
      l = ($urandom_range(0, 15) == 0);
      e = ($urandom_range(0, 1) == 1);
      tick(r, l, e, {$urandom, $urandom, $urandom, $urandom});
    end

    tick(0, 0, 0, '0);
    tick(0, 0, 0, '0);
    settle();
    @(negedge clk);
    #1;
    chk("scoreboard drained", 128'(sb_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
